// File: rtl/cam_rgb565_to_ram_capture.sv
// cam_rgb565_to_ram_capture: samples an OV7670 RGB565 stream on the system clock and writes RGB332 pixels into a frame buffer.
`timescale 1ns/1ps
module cam_rgb565_to_ram_capture #(
   parameter int CAM_SCREEN_X = 160,
   parameter int CAM_SCREEN_Y = 120,
   parameter int AW = 15,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cam_pclk,
   input  logic          cam_href,
   input  logic          cam_vsync,
   input  logic [7:0]    cam_d,
   input  logic          capture_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   output logic          mem_we,
   output logic          frame_done,
   output logic          line_err,
   output logic          overflow
);
   typedef enum logic [1:0] {WAIT_VS, ARMED, CAPTURE} state_t;
   localparam logic [AW-1:0] SX = AW'(CAM_SCREEN_X);
   localparam logic [AW-1:0] SY = AW'(CAM_SCREEN_Y);
   logic [1:0] pclk_sq, href_sq, vs_sq;
   logic [7:0] d1_q, d2_q;
   logic pclk_prev_q, href_prev_q, vs_prev_q;
   state_t state_q, state_d;
   logic [AW-1:0] col_q, col_d, row_q, row_d, row_base_q, row_base_d, mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_data_q, mem_data_d;
   logic [5:0] hi_q, hi_d;
   logic phase_q, phase_d, mem_we_q, mem_we_d, frame_done_q, frame_done_d;
   logic line_err_q, line_err_d, overflow_q, overflow_d;
   logic pclk_rise, href, vs, href_fall, vs_rise, vs_fall, byte_ok, line_end, in_win;
   // All camera pins share the same sync depth so href/d stay aligned with the pclk edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pclk_sq <= '0;
         href_sq <= '0;
         vs_sq <= '0;
         d1_q <= '0;
         d2_q <= '0;
         pclk_prev_q <= 1'b0;
         href_prev_q <= 1'b0;
         vs_prev_q <= 1'b0;
      end else begin
         pclk_sq <= {pclk_sq[0], cam_pclk};
         href_sq <= {href_sq[0], cam_href};
         vs_sq <= {vs_sq[0], cam_vsync};
         d1_q <= cam_d;
         d2_q <= d1_q;
         pclk_prev_q <= pclk_sq[1];
         href_prev_q <= href_sq[1];
         vs_prev_q <= vs_sq[1];
      end
   end
   assign pclk_rise = pclk_sq[1] & ~pclk_prev_q;
   assign href = href_sq[1];
   assign vs = vs_sq[1];
   assign href_fall = href_prev_q & ~href;
   assign vs_rise = vs & ~vs_prev_q;
   assign vs_fall = ~vs & vs_prev_q;
   assign byte_ok = (state_q == CAPTURE) && pclk_rise && href;
   assign line_end = (state_q == CAPTURE) && (href_fall || vs_rise);
   assign in_win = (col_q < SX) && (row_q < SY);
   always_comb begin
      state_d = state_q;
      col_d = col_q;
      row_d = row_q;
      row_base_d = row_base_q;
      hi_d = hi_q;
      phase_d = phase_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mem_we_d = 1'b0;
      frame_done_d = 1'b0;
      line_err_d = line_err_q;
      overflow_d = overflow_q;
      if (state_q == WAIT_VS && vs) state_d = ARMED;
      if (state_q == ARMED && vs_fall) begin
         state_d = capture_en ? CAPTURE : WAIT_VS;
         if (capture_en) begin
            col_d = '0;
            row_d = '0;
            row_base_d = '0;
            line_err_d = 1'b0;
            overflow_d = 1'b0;
            phase_d = 1'b0;
         end
      end
      if (byte_ok) begin
         phase_d = ~phase_q;
         if (!phase_q) hi_d = {d2_q[7:5], d2_q[2:0]};
         else if (in_win) begin
            mem_we_d = 1'b1;
            mem_data_d = DW'({hi_q, d2_q[4:3]});
            mem_addr_d = row_base_q + col_q;
            col_d = col_q + 1'b1;
         end else overflow_d = 1'b1;
      end
      // col only moves while row is inside the window, so row/row_base saturate at the window edge
      if (line_end) begin
         if (phase_q) begin
            line_err_d = 1'b1;
            phase_d = 1'b0;
         end
         if (col_q != '0) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            row_base_d = row_base_q + SX;
         end
      end
      if (state_q == CAPTURE && vs_rise) begin
         frame_done_d = 1'b1;
         state_d = ARMED;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= WAIT_VS;
         col_q <= '0;
         row_q <= '0;
         row_base_q <= '0;
         hi_q <= '0;
         phase_q <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_we_q <= 1'b0;
         frame_done_q <= 1'b0;
         line_err_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q <= col_d;
         row_q <= row_d;
         row_base_q <= row_base_d;
         hi_q <= hi_d;
         phase_q <= phase_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mem_we_q <= mem_we_d;
         frame_done_q <= frame_done_d;
         line_err_q <= line_err_d;
         overflow_q <= overflow_d;
      end
   end
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign mem_we = mem_we_q;
   assign frame_done = frame_done_q;
   assign line_err = line_err_q;
   assign overflow = overflow_q;
endmodule

// File: tb/tb_cam_rgb565_to_ram_capture.sv
// tb_cam_rgb565_to_ram_capture: directed camera frames with a write scoreboard for cam_rgb565_to_ram_capture.
`timescale 1ns/1ps
module tb_cam_rgb565_to_ram_capture;
   localparam int SX = 160;
   localparam int SY = 120;
   typedef struct packed {logic [14:0] a; logic [7:0] d;} wr_t;
   logic clk = 1'b0, rst = 1'b0, cam_pclk = 1'b1, cam_href = 1'b0, cam_vsync = 1'b0, capture_en = 1'b1;
   logic [7:0] cam_d = '0;
   logic [14:0] mem_addr;
   logic [7:0] mem_data;
   logic mem_we, frame_done, line_err, overflow;
   wr_t q[$];
   int vectors = 0, errs = 0, fd_cnt = 0, wr_cnt = 0, m_row = 0, m_col = 0, fd0, w0;
   bit cap_on = 0;
   logic we_prev = 1'b0, fd_prev = 1'b0;
   logic [14:0] last_addr = '0;
   cam_rgb565_to_ram_capture dut (
      .clk(clk), .rst(rst), .cam_pclk(cam_pclk), .cam_href(cam_href), .cam_vsync(cam_vsync),
      .cam_d(cam_d), .capture_en(capture_en), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_we(mem_we), .frame_done(frame_done), .line_err(line_err), .overflow(overflow)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      wr_t e;
      if (mem_we) begin
         wr_cnt++;
         chk("we_width", 32'(we_prev), 0);
         chk("addr_in_window", 32'(mem_addr < 15'(SX * SY)), 1);
         chk("pending_write", 32'(q.size() > 0), 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.a));
            chk("wr_data", 32'(mem_data), 32'(e.d));
         end
         last_addr = mem_addr;
      end
      if (frame_done) begin
         chk("fd_width", 32'(fd_prev), 0);
         fd_cnt++;
      end
      we_prev = mem_we;
      fd_prev = frame_done;
   end
   function automatic logic [7:0] rgb332(input logic [7:0] hi, input logic [7:0] lo);
      return {hi[7:5], hi[2:0], lo[4:3]};
   endfunction
   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic send_byte(input logic [7:0] b);
      cam_d = b;
      cam_pclk = 1'b0;
      wclk(2);
      cam_pclk = 1'b1;
      wclk(2);
   endtask
   task automatic send_pix(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] exp);
      send_byte(hi);
      send_byte(lo);
      if (cap_on && m_col < SX && m_row < SY) q.push_back('{a: 15'(m_row * SX + m_col), d: exp});
      m_col++;
   endtask
   task automatic rand_pix();
      logic [7:0] h, l;
      h = 8'($urandom);
      l = 8'($urandom);
      send_pix(h, l, rgb332(h, l));
   endtask
   task automatic line_begin();
      cam_href = 1'b1;
      wclk(2);
   endtask
   task automatic line_end();
      cam_href = 1'b0;
      wclk(8);
      if (m_col > 0) m_row++;
      m_col = 0;
   endtask
   task automatic rand_line(input int n);
      line_begin();
      repeat (n) rand_pix();
      line_end();
   endtask
   task automatic frame_start(input bit en);
      capture_en = en;
      cam_vsync = 1'b1;
      wclk(8);
      cam_vsync = 1'b0;
      wclk(8);
      cap_on = en;
      m_row = 0;
      m_col = 0;
   endtask
   task automatic frame_end();
      cam_vsync = 1'b1;
      wclk(8);
   endtask
   task automatic chk_zero(input string tag);
      chk(tag, 32'({mem_addr, mem_data, mem_we, frame_done, line_err, overflow}), 0);
   endtask
   initial begin
      for (int i = 0; i < 6; i++) begin
         cam_pclk = 1'($urandom);
         cam_href = 1'($urandom);
         cam_vsync = 1'($urandom);
         cam_d = 8'($urandom);
         wclk(3);
         chk_zero("reset_outputs");
      end
      cam_pclk = 1'b1;
      cam_href = 1'b0;
      cam_vsync = 1'b0;
      wclk(1);
      rst = 1'b1;
      wclk(4);
      rand_line(4);
      chk("no_write_before_vsync", 32'(wr_cnt), 0);
      frame_start(1);
      chk("flags_at_start", 32'({line_err, overflow}), 0);
      for (int l = 0; l < 2; l++) begin
         line_begin();
         send_pix(8'hF8, 8'h00, 8'hE0);
         send_pix(8'h07, 8'hE0, 8'h1C);
         send_pix(8'h00, 8'h1F, 8'h03);
         line_end();
      end
      fd0 = fd_cnt;
      frame_end();
      chk("basic_frame_done", 32'(fd_cnt - fd0), 1);
      chk("basic_drained", 32'(q.size()), 0);
      chk("basic_last_addr", 32'(last_addr), 162);
      chk("basic_flags", 32'({line_err, overflow}), 0);
      frame_start(1);
      rand_line(170);
      chk("wide_overflow", 32'(overflow), 1);
      chk("wide_last_addr", 32'(last_addr), 159);
      frame_end();
      chk("wide_drained", 32'(q.size()), 0);
      frame_start(1);
      chk("overflow_cleared", 32'(overflow), 0);
      repeat (119) rand_line(1);
      rand_line(160);
      chk("tall_last_addr", 32'(last_addr), 19199);
      chk("tall_full_no_overflow", 32'(overflow), 0);
      repeat (5) rand_line(2);
      chk("tall_overflow", 32'(overflow), 1);
      chk("tall_last_addr_held", 32'(last_addr), 19199);
      frame_end();
      chk("tall_drained", 32'(q.size()), 0);
      frame_start(1);
      line_begin();
      rand_pix();
      rand_pix();
      send_byte(8'($urandom));
      line_end();
      chk("odd_line_err", 32'(line_err), 1);
      rand_line(2);
      frame_end();
      chk("odd_last_addr", 32'(last_addr), 161);
      chk("odd_flags_held", 32'({line_err, overflow}), 32'b10);
      chk("odd_drained", 32'(q.size()), 0);
      frame_start(1);
      chk("line_err_cleared", 32'(line_err), 0);
      frame_end();
      fd0 = fd_cnt;
      w0 = wr_cnt;
      frame_start(0);
      rand_line(3);
      rand_line(3);
      frame_end();
      chk("disabled_writes", 32'(wr_cnt - w0), 0);
      chk("disabled_frame_done", 32'(fd_cnt - fd0), 0);
      frame_start(1);
      rand_line(3);
      frame_end();
      chk("reenabled_last_addr", 32'(last_addr), 2);
      chk("reenabled_frame_done", 32'(fd_cnt - fd0), 1);
      chk("reenabled_drained", 32'(q.size()), 0);
      frame_start(1);
      line_begin();
      repeat (50) rand_pix();
      wclk(4);
      chk("midline_drained", 32'(q.size()), 0);
      #3 rst = 1'b0;
      #1 chk_zero("midline_reset_outputs");
      @(negedge clk);
      cam_href = 1'b0;
      wclk(2);
      rst = 1'b1;
      wclk(4);
      chk_zero("after_reset_release");
      frame_start(1);
      rand_line(4);
      rand_line(3);
      frame_end();
      chk("post_reset_last_addr", 32'(last_addr), 162);
      chk("post_reset_drained", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/cam_rgb565_to_ram_capture.md
Name: cam_rgb565_to_ram_capture

Overview:
- Upstream stage of the camera frame buffer: captures OV7670 RGB565 pixel stream, packs each pixel to RGB332, writes the dual-port buffer's write port (addr/data/write-enable).
- Runs entirely on the system clock. Camera pins are synchronized and PCLK is edge-detected, so no camera-clock domain exists in the fabric.
- Requires PCLK ≤ clk/4, set via camera prescaler.

Parameters:
- CAM_SCREEN_X, 160, pixels per stored line.
- CAM_SCREEN_Y, 120, stored lines per frame.
- AW, 15, buffer address width (≥ log2(CAM_SCREEN_X*CAM_SCREEN_Y+1)).
- DW, 8, buffer data width (RGB332).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- cam_pclk  in  1  camera pixel clock, sampled as data.
- cam_href  in  1  camera line-valid.
- cam_vsync  in  1  camera frame sync (high = vertical blanking).
- cam_d  in  8  camera data byte.
- capture_en  in  1  1 = accept new frames; sampled only at frame start.
- mem_addr  out  AW  buffer write address.
- mem_data  out  DW  RGB332 pixel.
- mem_we  out  1  one-clk write strobe.
- frame_done  out  1  one-clk pulse at end of each captured frame.
- line_err  out  1  sticky flag: odd byte count on a line; cleared at next frame start.
- overflow  out  1  sticky flag: pixels/lines beyond the window were dropped; cleared at next frame start.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0: mem_addr, mem_data, mem_we, frame_done, line_err, overflow.
  - State = WAIT_VS; counters, synchronizers and byte latch are cleared.
- Synchronization:
  - cam_pclk, cam_href, cam_vsync and cam_d each pass through an identical 2-FF synchronizer, keeping them mutually aligned.
  - A third PCLK register provides edge detection. pclk_rise = sync=1 and prev=0.
  - Byte sampling uses the synchronized href/d in the pclk_rise cycle.
- States:
  - WAIT_VS: wait for synchronized vsync=1 → ARMED.
  - ARMED: on vsync 1→0:
    - If capture_en=1: clear col, row, row_base, line_err, overflow, byte phase → CAPTURE.
    - Else → WAIT_VS.
  - CAPTURE: on pclk_rise with href=1:
    - Phase 0: latch byte as hi.
    - Phase 1: form pixel = {hi[7:5], hi[2:0], byte[4:3]}, i.e. R[4:2], G[5:3], B[4:3].
    - Phase toggles on every accepted byte.
  - CAPTURE on vsync 0→1: pulse frame_done for 1 clk → ARMED. Any partial line is still counted as a row.
- Write timing:
  - Pixel completes in cycle t (phase-1 pclk_rise). In cycle t+1: mem_we=1, mem_data=pixel, mem_addr=row_base+col.
  - mem_we returns to 0 at t+2; mem_addr/mem_data hold until the next write.
  - Then col increments.
- Window bounds:
  - If col ≥ CAM_SCREEN_X or row ≥ CAM_SCREEN_Y: no write, overflow=1.
  - Address never exceeds CAM_SCREEN_X*CAM_SCREEN_Y-1. Address CAM_SCREEN_X*CAM_SCREEN_Y is reserved as the display background and is never written.
- Line end (href 1→0 in CAPTURE):
  - If phase=1: discard hi, set line_err, phase=0.
  - If col>0: row += 1, row_base += CAM_SCREEN_X, col=0. Lines with zero pixels do not advance row.
- Short lines: unwritten columns keep old buffer content.
- Frame writes:
  - Each frame starts at address 0.
  - No read-modify-write; width arithmetic is AW-bit, no wrap possible given the bounds above.
- Other rules:
  - href=1 outside CAPTURE is ignored.
  - pclk_rise with href=0 is ignored.
  - Simultaneous href fall and vsync rise in the same cycle: line-end processing first, then frame_done.
  - Reset mid-frame aborts immediately; the next capture waits for a full vsync high→low.

Test Plan:
- Reset: hold rst=0 with toggling camera inputs → all outputs 0, no mem_we. Release rst → no writes until a vsync 1→0.
- Basic frame: 2 lines × 3 pixels, bytes (0xF8,0x00)… → writes at addr 0,1,2,160,161,162. Pixel 0xF800 → data 0xE0. 0x07E0 → 0x1C. 0x001F → 0x03. frame_done one pulse after vsync rises.
- Oversize:
  - Line of 170 pixels → addr 0..159 written, overflow=1.
  - 125 lines → last write addr 19199, no write to addr 19200.
- Odd byte count: line of 5 bytes → 2 writes, line_err=1. Next line starts at addr 160, phase 0. Flags clear at next frame start.
- capture_en=0 at vsync fall → zero writes that frame, no frame_done. Re-enable → next frame captured from addr 0.
- Reset mid-line (after 50 pixels) → outputs 0 immediately. Next complete frame writes from addr 0 with correct data.
